// File: rtl/demux_wb_dest_3.sv
// Write-back destination demux: a 2-entry request FIFO feeding one-hot register-file write strobes.
// Optional dual-destination writes are compiled in with `define DEMUX_DUAL_WRITE_EN.
module demux_wb_dest_3 #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         resetN,
    input  logic         inValid,
    output logic         inReady,
    input  logic [W-1:0] inData,
    input  logic [2:0]   destA,
    input  logic [2:0]   destB,
    input  logic         ctrlSlct,
`ifdef DEMUX_DUAL_WRITE_EN
    input  logic         dualWr,
`endif
    input  logic         wbStall,
    output logic [7:0]   wrEn,
    output logic [2:0]   wrAddr,
    output logic [W-1:0] wrData,
    output logic         busy
);

    typedef enum logic [0:0] {
        HeadFirst,
        HeadSecond
    } state_e;

    state_e       state_q, state_d;
    logic [1:0]   count_q, count_d;
    logic         wptr_q, rptr_q;

    logic [W-1:0] data_q  [2];
    logic [2:0]   dest1_q [2];
`ifdef DEMUX_DUAL_WRITE_EN
    logic [2:0]   dest2_q [2];
    logic         two_q   [2];
    logic         ent_two;
`endif

    logic         push, pop, issue;
    logic [2:0]   ent_dest1;
    logic [2:0]   issue_dest;
    logic [7:0]   issue_en;

    // Status is decoded from registered count only, so no input-to-ready path.
    assign inReady = (count_q != 2'd2);
    assign busy    = (count_q != 2'd0);
    assign push    = inValid && inReady;
    assign issue   = (count_q != 2'd0) && !wbStall;

    // Resolve destinations at capture time so the issue side never looks at ctrlSlct.
    always_comb begin
        ent_dest1 = ctrlSlct ? destB : destA;
`ifdef DEMUX_DUAL_WRITE_EN
        ent_two = 1'b0;
        if (dualWr) begin
            ent_dest1 = destA;
            ent_two   = (destA != destB);
        end
`endif
    end

    always_comb begin
        issue_dest = dest1_q[rptr_q];
        pop        = issue;
        state_d    = state_q;
`ifdef DEMUX_DUAL_WRITE_EN
        if (issue) begin
            unique case (state_q)
                HeadFirst: begin
                    if (two_q[rptr_q]) begin
                        pop     = 1'b0;
                        state_d = HeadSecond;
                    end
                end
                HeadSecond: begin
                    issue_dest = dest2_q[rptr_q];
                    state_d    = HeadFirst;
                end
                default: state_d = HeadFirst;
            endcase
        end
`endif
    end

    // Register 0 is hardwired zero: the slot is consumed but no strobe fires.
    always_comb begin
        issue_en = 8'h00;
        if (issue_dest != 3'd0) begin
            issue_en = 8'h01 << issue_dest;
        end
    end

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= HeadFirst;
            count_q <= 2'd0;
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            wrEn    <= 8'h00;
            wrAddr  <= 3'd0;
            wrData  <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            if (push) begin
                wptr_q <= ~wptr_q;
            end
            if (pop) begin
                rptr_q <= ~rptr_q;
            end
            if (issue) begin
                wrEn   <= issue_en;
                wrAddr <= issue_dest;
                wrData <= data_q[rptr_q];
            end else begin
                wrEn   <= 8'h00;
            end
        end
    end

    // Entry storage needs no reset: only slots covered by count are ever read.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wptr_q]  <= inData;
            dest1_q[wptr_q] <= ent_dest1;
`ifdef DEMUX_DUAL_WRITE_EN
            dest2_q[wptr_q] <= destB;
            two_q[wptr_q]   <= ent_two;
`endif
        end
    end

endmodule

// File: tb/tb_demux_wb_dest_3.sv
// Scoreboard bench for demux_wb_dest_3: a queue-of-writes model predicts each edge's outputs,
// a negedge monitor compares. Dual-write cases run when DEMUX_DUAL_WRITE_EN is defined.
module tb_demux_wb_dest_3;

`ifdef DEMUX_DUAL_WRITE_EN
    localparam bit DualEn = 1'b1;
`else
    localparam bit DualEn = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        inReady;
    logic [15:0] inData;
    logic [2:0]  destA, destB;
    logic        ctrlSlct;
    logic        dual_wr;
    logic        wbStall;
    logic [7:0]  wrEn;
    logic [2:0]  wrAddr;
    logic [15:0] wrData;
    logic        busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    demux_wb_dest_3 #(.W(16)) dut (
        .clk      (clk),
        .resetN   (resetN),
        .inValid  (inValid),
        .inReady  (inReady),
        .inData   (inData),
        .destA    (destA),
        .destB    (destB),
        .ctrlSlct (ctrlSlct),
`ifdef DEMUX_DUAL_WRITE_EN
        .dualWr   (dual_wr),
`endif
        .wbStall  (wbStall),
        .wrEn     (wrEn),
        .wrAddr   (wrAddr),
        .wrData   (wrData),
        .busy     (busy)
    );

    // Pending register writes in issue order; 'last' marks the final write of a request.
    typedef struct packed {
        logic [2:0]  addr;
        logic [15:0] data;
        logic        last;
    } wr_t;

    typedef struct packed {
        logic [7:0]  en;
        logic [2:0]  addr;
        logic [15:0] data;
        logic        rdy;
        logic        bsy;
    } exp_t;

    wr_t  pend[$];
    exp_t sb[$];
    logic [2:0]  last_addr;
    logic [15:0] last_data;

    function automatic int n_entries();
        int n = 0;
        foreach (pend[i]) if (pend[i].last) n++;
        return n;
    endfunction

    task automatic model_edge();
        exp_t e;
        wr_t  w;
        bit   rdy, acc, iss;
        rdy = (n_entries() != 2);
        acc = inValid && rdy;
        iss = (pend.size() != 0) && !wbStall;
        e.en = 8'h00;
        if (!resetN) begin
            pend.delete();
            last_addr = 3'd0;
            last_data = 16'h0000;
        end else begin
            if (iss) begin
                w = pend.pop_front();
                last_addr = w.addr;
                last_data = w.data;
                e.en = (w.addr == 3'd0) ? 8'h00 : 8'(1 << w.addr);
            end
            if (acc) begin
                if (DualEn && dual_wr && destA != destB) begin
                    pend.push_back('{addr: destA, data: inData, last: 1'b0});
                    pend.push_back('{addr: destB, data: inData, last: 1'b1});
                end else if (DualEn && dual_wr) begin
                    pend.push_back('{addr: destA, data: inData, last: 1'b1});
                end else begin
                    pend.push_back('{addr: ctrlSlct ? destB : destA, data: inData, last: 1'b1});
                end
            end
        end
        e.addr = last_addr;
        e.data = last_data;
        e.rdy  = (n_entries() != 2);
        e.bsy  = (n_entries() != 0);
        sb.push_back(e);
    endtask

    initial forever begin
        @(posedge clk);
        model_edge();
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
        end
    endtask

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("wrEn",    32'(wrEn),    32'(e.en));
            chk("wrAddr",  32'(wrAddr),  32'(e.addr));
            chk("wrData",  32'(wrData),  32'(e.data));
            chk("inReady", 32'(inReady), 32'(e.rdy));
            chk("busy",    32'(busy),    32'(e.bsy));
        end
    end

    // Offer a request until the DUT takes it; stall applies to the first offer only.
    task automatic send(input logic [15:0] d, input logic [2:0] a, input logic [2:0] b,
                        input logic s, input logic dl, input logic st);
        bit done = 1'b0;
        for (int t = 0; t < 64 && !done; t++) begin
            @(negedge clk);
            inValid  = 1'b1;
            inData   = d;
            destA    = a;
            destB    = b;
            ctrlSlct = s;
            dual_wr  = dl;
            wbStall  = (t == 0) ? st : 1'b0;
            done     = inReady;
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL send_timeout at %0t: actual=not_accepted required=accepted", $time);
        end
    endtask

    task automatic idle(input int n, input logic st);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            inValid  = 1'b0;
            inData   = 16'($urandom);
            destA    = 3'($urandom);
            destB    = 3'($urandom);
            ctrlSlct = 1'($urandom);
            wbStall  = st;
        end
    endtask

    initial begin
        resetN   = 1'b0;
        inValid  = 1'b1;
        inData   = 16'hFFFF;
        destA    = 3'd7;
        destB    = 3'd7;
        ctrlSlct = 1'b0;
        dual_wr  = 1'b0;
        wbStall  = 1'b0;
        repeat (2) @(negedge clk);
        resetN  = 1'b1;
        inValid = 1'b0;
        idle(1, 1'b0);

        send(16'hBEEF, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        send(16'h1234, 3'd0, 3'd7, 1'b0, 1'b0, 1'b0);
        idle(3, 1'b0);

        // Fill under stall, third request rejected until the stall lifts.
        send(16'h0001, 3'd1, 3'd0, 1'b0, 1'b0, 1'b1);
        send(16'h0002, 3'd2, 3'd0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        inValid = 1'b1;
        inData  = 16'h0004;
        destA   = 3'd4;
        wbStall = 1'b1;
        send(16'h0004, 3'd4, 3'd0, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);

`ifdef DEMUX_DUAL_WRITE_EN
        send(16'h00AA, 3'd2, 3'd6, 1'b0, 1'b1, 1'b0);
        idle(4, 1'b0);
        send(16'h0055, 3'd6, 3'd6, 1'b1, 1'b1, 1'b0);
        idle(4, 1'b0);
        send(16'h00CC, 3'd2, 3'd6, 1'b0, 1'b1, 1'b0);
        idle(1, 1'b0);
        @(negedge clk);
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        idle(3, 1'b0);
`endif

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle(int'($urandom_range(1, 3)), 1'($urandom_range(0, 2) == 0));
            end else begin
                send(16'($urandom), 3'($urandom), 3'($urandom), 1'($urandom),
                     DualEn ? 1'($urandom) : 1'b0, 1'($urandom_range(0, 3) == 0));
            end
        end

        idle(12, 1'b0);
        for (int t = 0; t < 8 && sb.size() != 0; t++) @(negedge clk);
        checks++;
        if (pend.size() != 0 || sb.size() != 0) begin
            errors++;
            $display("FAIL drain: actual=%0d pending required=0", pend.size() + sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_wb_dest_3.md
# demux_wb_dest_3

Write-back destination demultiplexer: the write-side counterpart of the 3-bit destination-select mux. It takes a result word plus two candidate register numbers and a select bit, and buffers the request in a 2-entry FIFO. It then steers the word to exactly one register-file write strobe per cycle. It sits between the execute/write-back stage and the 8-entry register file.

## Interface

Parameters:

- `W`, 16, data word width

Ports:

- `clk` input 1: single clock, all state updates on rising edge
- `resetN` input 1: synchronous, active-low reset
- `inValid` input 1: request present
- `inReady` output 1: block can accept a request this cycle
- `inData` input W: result word
- `destA` input 3: first candidate register number
- `destB` input 3: second candidate register number
- `ctrlSlct` input 1: 0 selects `destA`, 1 selects `destB`
- `dualWr` input 1: present only with `DEMUX_DUAL_WRITE_EN`; write word to both destinations
- `wbStall` input 1: register file busy; no write issued this cycle
- `wrEn` output 8: one-hot register write strobe, registered
- `wrAddr` output 3: binary index of the strobed register, registered
- `wrData` output W: word being written, registered
- `busy` output 1: FIFO non-empty or a write is in progress

## Operation

- **Accept:** a request is accepted on an edge where `inValid && inReady`.
- **Entry capture:** the entry stores `inData`, a resolved first destination (`ctrlSlct ? destB : destA`), and, in dual mode, a second destination.
- **FIFO:** 2 entries, with a 2-bit count in the range 0..2.
  - `inReady = (count != 2)`, decoded from registered state only; there is no combinational path from `inValid` or `wbStall`.
- **Issue:** on each edge where the FIFO is non-empty and `wbStall` is 0, the head entry issues one write.
  - The write is a registered `wrEn = 1 << dest`, with `wrAddr = dest` and `wrData = data`.
- **Register 0:** it is hardwired zero. A write to dest 0 consumes its issue slot with `wrEn = 8'h00`; `wrAddr` and `wrData` are still updated.
- **No issue:** on any edge with no issue, `wrEn = 8'h00`, and `wrAddr` and `wrData` hold their previous values.
- **FSM states:**
  - `HEAD_FIRST`: issue the first destination. For a single write, pop the entry. For a dual write, go to `HEAD_SECOND`.
  - `HEAD_SECOND`: issue the second destination, pop the entry, return to `HEAD_FIRST`.
- **Stall:** `wbStall` freezes the FSM and FIFO pop. Pushes still occur if `inReady` is 1.
- **Push and pop together:** allowed when count is 1; count stays at 1. At count 2, `inReady` is 0, so only a pop occurs.
- **Busy:** `busy = (count != 0)`.

## Timing

- **Reset:** `resetN` low at an edge forces `wrEn = 0`, `wrAddr = 0`, `wrData = 0`, count 0, FSM to `HEAD_FIRST`, and `inReady = 1`.
- **Reset mid-operation:** any in-flight entry, including a pending second write, is discarded.
- **Latency:** a request accepted at edge N into an empty FIFO with no stall drives `wrEn` at edge N+1 and remains visible for one cycle.
- **Throughput:** one write per cycle sustained. A dual entry occupies 2 issue cycles.
- **Same-cycle accept and issue:** an entry accepted at edge N cannot issue at edge N.
- **Wrap:** FIFO read and write pointers are 1 bit each and wrap 1→0.

## Configuration

- **`DEMUX_DUAL_WRITE_EN` defined:**
  - The `dualWr` port exists.
  - With `dualWr = 1`, the entry's first destination is `destA` and its second is `destB`; `ctrlSlct` is ignored.
  - If `destA == destB`, only one write issues and `HEAD_SECOND` is skipped.
- **`DEMUX_DUAL_WRITE_EN` undefined:**
  - There is no `dualWr` port and the FSM never leaves `HEAD_FIRST`.
  - Every entry issues exactly one write.

## Test plan

- **Reset:** hold `resetN = 0` for 2 edges with `inValid = 1` → `wrEn = 0`, `wrAddr = 0`, `wrData = 0`, `busy = 0`. `inReady = 1` at the first edge after release.
- **Single write:** `inData = 16'hBEEF`, `destA = 3`, `destB = 5`, `ctrlSlct = 1`, accepted at edge N → edge N+1 gives `wrEn = 8'h20`, `wrAddr = 5`, `wrData = 16'hBEEF`. Edge N+2 gives `wrEn = 0`.
- **Register 0 drop:** `destA = 0`, `ctrlSlct = 0`, `inData = 16'h1234` → the issue edge gives `wrEn = 8'h00`, `wrData = 16'h1234`; `busy` returns to 0 the next cycle.
- **Full/stall:** assert `wbStall = 1` and offer 3 back-to-back requests (dest 1, 2, 4) → 2 are accepted and `inReady = 0` on the third. Release the stall → `wrEn` goes `8'h02`, `8'h04` on consecutive edges, then the third is accepted and gives `8'h10`.
- **Dual write (macro on):** `dualWr = 1`, `destA = 2`, `destB = 6`, `inData = 16'h00AA` → `wrEn = 8'h04` then `8'h40` on consecutive edges. With `destA = destB = 6`, only one `8'h40` pulse.
- **Reset mid-dual:** `resetN = 0` on the edge after the first dual write → no `8'h40` pulse; `count = 0` and `busy = 0` afterward.
